// File: rtl/fk_delay_pkg.sv
// -----------------------------------------------------------------------------
// fk_delay_pkg
// Shared constants and width helpers for the fk_delay_line block.
//   chan_w(C)  : channel-select width, max(1, clog2(C))
//   sum_w(W,D) : width of the sign-extended sum of D W-bit samples
// -----------------------------------------------------------------------------
package fk_delay_pkg;

  // Base fixed-point width; samples are 2*N bits wide.
  localparam int N_DEFAULT = 25;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int chan_w(input int c);
    int w;
    w = $clog2(c);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

  // Sum of D samples grows by clog2(D) bits and so can never overflow.
  function automatic int sum_w(input int w, input int d);
    return w + $clog2(d);
  endfunction

endpackage

// File: rtl/fk_delay_line_if.sv
// -----------------------------------------------------------------------------
// fk_delay_line_if
// Sample-in / snapshot-out bundle of the fk_delay_line.
//   master : sample producer (drives shift, clr, ch_sel, in_data)
//   slave  : fk_delay_line (drives taps, out_ch, out_valid, primed, err, tap_sum)
// Parameters W (sample width), D (taps) and C (channels) must match the DUT.
// -----------------------------------------------------------------------------
interface fk_delay_line_if #(
  parameter int W = 50,
  parameter int D = 3,
  parameter int C = 1
);
  import fk_delay_pkg::*;

  localparam int CW = chan_w(C);
  localparam int SW = sum_w(W, D);

  logic              shift;
  logic              clr;
  logic [CW-1:0]     ch_sel;
  logic [W-1:0]      in_data;
  logic [D*W-1:0]    taps;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              primed;
  logic              err;
  logic [SW-1:0]     tap_sum;

  modport master (
    output shift, clr, ch_sel, in_data,
    input  taps, out_ch, out_valid, primed, err, tap_sum
  );

  modport slave (
    input  shift, clr, ch_sel, in_data,
    output taps, out_ch, out_valid, primed, err, tap_sum
  );

endinterface

// File: rtl/fk_delay_chan.sv
// -----------------------------------------------------------------------------
// fk_delay_chan
// One channel of history: a D-tap shift register of W-bit samples plus a fill
// counter that saturates at D. The post-update values are exported so the top
// level can snapshot exactly what this edge writes.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   shift      : push in_data into tap 0 (already qualified by channel decode)
//   clr        : clear history and fill; combined with shift, clear then push
//   in_data    : new sample
//   hist_next  : history as it will be after this edge (tap 0 in low bits)
//   fill_next  : fill count as it will be after this edge
// -----------------------------------------------------------------------------
module fk_delay_chan #(
  parameter int W = 50,
  parameter int D = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift,
  input  logic                      clr,
  input  logic [W-1:0]              in_data,
  output logic [D*W-1:0]            hist_next,
  output logic [$clog2(D+1)-1:0]    fill_next
);
  import fk_delay_pkg::*;

  localparam int FW = $clog2(D + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(D);

  logic [D*W-1:0] hist_r;
  logic [FW-1:0]  fill_r;
  logic [D*W-1:0] hist_s;
  logic [FW-1:0]  fill_s;

  // Next-state: clear wins over the old contents, then the push is applied.
  always_comb begin
    hist_s = hist_r;
    fill_s = fill_r;
    if (clr && shift) begin
      hist_s = {{((D-1)*W){1'b0}}, in_data};
      fill_s = FW'(1);
    end else if (clr) begin
      hist_s = {(D*W){1'b0}};
      fill_s = {FW{1'b0}};
    end else if (shift) begin
      hist_s = {hist_r[(D-1)*W-1:0], in_data};
      if (fill_r == FILL_FULL) begin
        fill_s = FILL_FULL;
      end else begin
        fill_s = fill_r + FW'(1);
      end
    end else begin
      hist_s = hist_r;
      fill_s = fill_r;
    end
  end

  // History and fill state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= {(D*W){1'b0}};
      fill_r <= {FW{1'b0}};
    end else begin
      hist_r <= hist_s;
      fill_r <= fill_s;
    end
  end

  assign hist_next = hist_s;
  assign fill_next = fill_s;

endmodule

// File: rtl/fk_delay_line.sv
// -----------------------------------------------------------------------------
// fk_delay_line
// D-deep history of W-bit signed samples for C time-multiplexed channels,
// feeding the difference-equation MAC datapath with fk, fk-1, ... fk-(D-1).
// Every accepted shift/clr returns a registered snapshot of the written
// channel one cycle later.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : shift, clr, ch_sel, in_data in;
//                     taps (fk in low W bits), out_ch, out_valid, primed,
//                     err (request to ch_sel >= C), tap_sum out
// Build option:
//   FK_DELAY_SUM_EN : when defined, tap_sum carries the registered signed sum
//                     of the snapshot taps; otherwise tap_sum is tied to 0.
// Legal parameters: D >= 2, C >= 1.
// -----------------------------------------------------------------------------
module fk_delay_line #(
  parameter int N = 25,
  parameter int W = 2 * N,
  parameter int D = 3,
  parameter int C = 1
) (
  input  logic            clk,
  input  logic            rst,
  fk_delay_line_if.slave  bus
);
  import fk_delay_pkg::*;

  localparam int CW    = chan_w(C);
  localparam int SW    = sum_w(W, D);
  localparam int FW    = $clog2(D + 1);
  localparam int NSLOT = 1 << CW;
  localparam logic [FW-1:0] FILL_FULL = FW'(D);

  logic           req_s;
  logic           in_range_s;
  logic           wr_ok_s;
  logic           err_s;
  logic [D*W-1:0] hist_next_a [NSLOT];
  logic [FW-1:0]  fill_next_a [NSLOT];
  logic [D*W-1:0] sel_hist_s;
  logic [FW-1:0]  sel_fill_s;

  logic [D*W-1:0] taps_r;
  logic [CW-1:0]  out_ch_r;
  logic           out_valid_r;
  logic           primed_r;
  logic           err_r;

  // Range check only exists when the select encoding has spare codes.
  if (C == NSLOT) begin : g_full_range
    assign in_range_s = 1'b1;
  end else begin : g_part_range
    localparam logic [CW:0] C_LIM = (CW+1)'(C);
    assign in_range_s = ({1'b0, bus.ch_sel} < C_LIM);
  end

  // Request qualification: valid writes go to a channel, others raise err.
  always_comb begin
    req_s   = bus.shift | bus.clr;
    wr_ok_s = req_s & in_range_s;
    err_s   = req_s & ~in_range_s;
  end

  // Slots beyond C read as zero so the snapshot mux index is always legal;
  // they are never selected for an update because err blocks the write.
  for (genvar c = 0; c < NSLOT; c++) begin : g_slot
    if (c < C) begin : g_chan
      logic sel_s;
      assign sel_s = wr_ok_s & (bus.ch_sel == CW'(c));
      fk_delay_chan #(
        .W (W),
        .D (D)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .shift     (bus.shift & sel_s),
        .clr       (bus.clr & sel_s),
        .in_data   (bus.in_data),
        .hist_next (hist_next_a[c]),
        .fill_next (fill_next_a[c])
      );
    end else begin : g_unused
      assign hist_next_a[c] = {(D*W){1'b0}};
      assign fill_next_a[c] = {FW{1'b0}};
    end
  end

  assign sel_hist_s = hist_next_a[bus.ch_sel];
  assign sel_fill_s = fill_next_a[bus.ch_sel];

  // Snapshot register: captures the post-update history of the written channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_r      <= {(D*W){1'b0}};
      out_ch_r    <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      primed_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      out_valid_r <= wr_ok_s;
      err_r       <= err_s;
      if (wr_ok_s) begin
        taps_r   <= sel_hist_s;
        out_ch_r <= bus.ch_sel;
        primed_r <= (sel_fill_s == FILL_FULL);
      end else begin
        taps_r   <= taps_r;
        out_ch_r <= out_ch_r;
        primed_r <= primed_r;
      end
    end
  end

  assign bus.taps      = taps_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_valid = out_valid_r;
  assign bus.primed    = primed_r;
  assign bus.err       = err_r;

`ifdef FK_DELAY_SUM_EN
  logic [SW-1:0] sum_s;
  logic [SW-1:0] sum_r;

  // Sign-extend each tap to the full sum width before adding.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < D; i++) begin
      sum_s = sum_s + {{(SW-W){sel_hist_s[i*W+W-1]}}, sel_hist_s[i*W +: W]};
    end
  end

  // Sum register, updated in lockstep with the taps snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= {SW{1'b0}};
    end else if (wr_ok_s) begin
      sum_r <= sum_s;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign bus.tap_sum = sum_r;
`else
  assign bus.tap_sum = {SW{1'b0}};
`endif

endmodule

// File: tb/tb_fk_delay_line.sv
// -----------------------------------------------------------------------------
// tb_fk_delay_line
// Self-checking bench for fk_delay_line (W=50, D=3, C=3). A behavioural model
// of every channel's history predicts each cycle's outputs; predictions are
// queued when stimulus is driven and compared when the DUT edge has happened.
// -----------------------------------------------------------------------------
module tb_fk_delay_line;
  import fk_delay_pkg::*;

  localparam int N  = 25;
  localparam int W  = 2 * N;
  localparam int D  = 3;
  localparam int C  = 3;
  localparam int CW = chan_w(C);
  localparam int SW = sum_w(W, D);

  typedef struct {
    logic           valid;
    logic           err;
    logic [D*W-1:0] taps;
    logic [CW-1:0]  ch;
    logic           primed;
    logic [SW-1:0]  sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fk_delay_line_if #(.W(W), .D(D), .C(C)) bus ();

  fk_delay_line #(.N(N), .W(W), .D(D), .C(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // reference model
  logic signed [W-1:0] mh [C][D];
  int                  mfill [C];
  logic [D*W-1:0]      snap_taps;
  logic [CW-1:0]       snap_ch;
  logic                snap_primed;
  logic [SW-1:0]       snap_sum;

  // scoreboard monitor: compare each queued prediction after its edge
  always @(posedge clk) begin
    #2;
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (bus.out_valid !== mon_e.valid) begin
        errors++; $display("FAIL sb_valid: got %b expected %b", bus.out_valid, mon_e.valid);
      end
      checks++;
      if (bus.err !== mon_e.err) begin
        errors++; $display("FAIL sb_err: got %b expected %b", bus.err, mon_e.err);
      end
      checks++;
      if (bus.taps !== mon_e.taps) begin
        errors++; $display("FAIL sb_taps: got %h expected %h", bus.taps, mon_e.taps);
      end
      checks++;
      if (bus.out_ch !== mon_e.ch) begin
        errors++; $display("FAIL sb_ch: got %0d expected %0d", bus.out_ch, mon_e.ch);
      end
      checks++;
      if (bus.primed !== mon_e.primed) begin
        errors++; $display("FAIL sb_primed: got %b expected %b", bus.primed, mon_e.primed);
      end
      checks++;
      if (bus.tap_sum !== mon_e.sum) begin
        errors++; $display("FAIL sb_sum: got %h expected %h", bus.tap_sum, mon_e.sum);
      end
    end
  end

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      for (int i = 0; i < D; i++) mh[c][i] = '0;
      mfill[c] = 0;
    end
    snap_taps   = '0;
    snap_ch     = '0;
    snap_primed = 1'b0;
    snap_sum    = '0;
  endtask

  // drive one cycle of stimulus, predict its outcome, release inputs after the edge
  task automatic step(input logic sh, input logic cl, input int ch, input logic [W-1:0] d);
    exp_t e;
`ifdef FK_DELAY_SUM_EN
    longint s;
`endif
    @(negedge clk);
    bus.shift   = sh;
    bus.clr     = cl;
    bus.ch_sel  = CW'(ch);
    bus.in_data = d;
    e.valid = 1'b0;
    e.err   = 1'b0;
    if (sh || cl) begin
      if (ch >= C) begin
        e.err = 1'b1;
      end else begin
        if (cl) begin
          for (int i = 0; i < D; i++) mh[ch][i] = '0;
          mfill[ch] = 0;
        end
        if (sh) begin
          for (int i = D - 1; i > 0; i--) mh[ch][i] = mh[ch][i-1];
          mh[ch][0] = d;
          if (mfill[ch] < D) mfill[ch]++;
        end
        for (int i = 0; i < D; i++) snap_taps[i*W +: W] = mh[ch][i];
        snap_ch     = CW'(ch);
        snap_primed = (mfill[ch] == D);
`ifdef FK_DELAY_SUM_EN
        s = 0;
        for (int i = 0; i < D; i++) s += longint'(mh[ch][i]);
        snap_sum = SW'(s);
`else
        snap_sum = '0;
`endif
        e.valid = 1'b1;
      end
    end
    e.taps   = snap_taps;
    e.ch     = snap_ch;
    e.primed = snap_primed;
    e.sum    = snap_sum;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.shift = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.taps !== '0) begin errors++; $display("FAIL rst_taps: got %h expected 0", bus.taps); end
    checks++; if (bus.out_ch !== '0) begin errors++; $display("FAIL rst_ch: got %0d expected 0", bus.out_ch); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.primed !== 1'b0) begin errors++; $display("FAIL rst_primed: got %b expected 0", bus.primed); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err); end
    checks++; if (bus.tap_sum !== '0) begin errors++; $display("FAIL rst_sum: got %h expected 0", bus.tap_sum); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [D*W-1:0] exp_taps;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 0, W'(10 * (k + 1)));
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid[%0d]: got %b expected 1", k, bus.out_valid); end
      checks++; if (bus.primed !== (k == 2)) begin errors++; $display("FAIL fill_primed[%0d]: got %b expected %b", k, bus.primed, (k == 2)); end
    end
    exp_taps = {W'(10), W'(20), W'(30)};
    checks++; if (bus.taps !== exp_taps) begin errors++; $display("FAIL fill_taps: got %h expected %h", bus.taps, exp_taps); end
    step(1'b0, 1'b0, 0, W'(0));
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", bus.out_valid); end
    step(1'b1, 1'b0, 0, W'(40));   // fill saturates, stays primed
    checks++; if (bus.primed !== 1'b1) begin errors++; $display("FAIL sat_primed: got %b expected 1", bus.primed); end
  endtask

  task automatic test_isolation();
    logic [D*W-1:0] exp_taps;
    step(1'b0, 1'b1, 0, W'(0));    // clr alone still snapshots
    checks++; if (bus.out_valid !== 1'b1 || bus.taps !== '0 || bus.primed !== 1'b0) begin
      errors++; $display("FAIL clr_snap: got v=%b taps=%h p=%b expected v=1 taps=0 p=0", bus.out_valid, bus.taps, bus.primed);
    end
    step(1'b1, 1'b0, 0, W'(5));
    step(1'b1, 1'b0, 1, W'(-7));
    step(1'b1, 1'b0, 0, W'(6));
    exp_taps = {W'(0), W'(5), W'(6)};
    checks++; if (bus.taps !== exp_taps || bus.out_ch !== CW'(0) || bus.primed !== 1'b0) begin
      errors++; $display("FAIL iso_ch0: got taps=%h ch=%0d p=%b expected taps=%h ch=0 p=0", bus.taps, bus.out_ch, bus.primed, exp_taps);
    end
    step(1'b1, 1'b0, 1, W'(1));
    exp_taps = {W'(0), W'(-7), W'(1)};
    checks++; if (bus.taps !== exp_taps || bus.out_ch !== CW'(1)) begin
      errors++; $display("FAIL iso_ch1: got taps=%h ch=%0d expected taps=%h ch=1", bus.taps, bus.out_ch, exp_taps);
    end
  endtask

  task automatic test_clr_shift();
    logic [D*W-1:0] exp_taps;
    step(1'b1, 1'b0, 0, W'(7));    // ch0 now primed
    checks++; if (bus.primed !== 1'b1) begin errors++; $display("FAIL cs_pre_primed: got %b expected 1", bus.primed); end
    step(1'b1, 1'b1, 0, W'(9));
    exp_taps = {W'(0), W'(0), W'(9)};
    checks++; if (bus.taps !== exp_taps || bus.primed !== 1'b0) begin
      errors++; $display("FAIL cs_clear_push: got taps=%h p=%b expected taps=%h p=0", bus.taps, bus.primed, exp_taps);
    end
    step(1'b1, 1'b0, 0, W'(4));
    exp_taps = {W'(0), W'(9), W'(4)};
    checks++; if (bus.taps !== exp_taps) begin errors++; $display("FAIL cs_next: got %h expected %h", bus.taps, exp_taps); end
  endtask

  task automatic test_out_of_range();
    logic [D*W-1:0] exp_taps;
    step(1'b1, 1'b0, 3, W'(99));
    checks++; if (bus.out_valid !== 1'b0 || bus.err !== 1'b1) begin
      errors++; $display("FAIL oor_shift: got v=%b err=%b expected v=0 err=1", bus.out_valid, bus.err);
    end
    exp_taps = {W'(0), W'(9), W'(4)};
    checks++; if (bus.taps !== exp_taps) begin errors++; $display("FAIL oor_hold: got %h expected %h", bus.taps, exp_taps); end
    step(1'b0, 1'b0, 0, W'(0));
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_pulse: got %b expected 0", bus.err); end
    step(1'b0, 1'b1, 3, W'(0));
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_clr: got %b expected 1", bus.err); end
    step(1'b1, 1'b0, 0, W'(5));
    exp_taps = {W'(9), W'(4), W'(5)};
    checks++; if (bus.taps !== exp_taps || bus.primed !== 1'b1) begin
      errors++; $display("FAIL oor_intact: got taps=%h p=%b expected taps=%h p=1", bus.taps, bus.primed, exp_taps);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    step(1'b0, 1'b1, 1, W'(0));
    for (int k = 0; k < 8; k++) begin
      r = {$urandom(), $urandom()};
      step(1'b1, 1'b0, 1, r[W-1:0]);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== CW'(1)) begin
        errors++; $display("FAIL b2b[%0d]: got v=%b ch=%0d expected v=1 ch=1", k, bus.out_valid, bus.out_ch);
      end
      checks++; if (bus.primed !== (k >= 2)) begin
        errors++; $display("FAIL b2b_primed[%0d]: got %b expected %b", k, bus.primed, (k >= 2));
      end
      checks++; if (bus.taps[W-1:0] !== r[W-1:0]) begin
        errors++; $display("FAIL b2b_fk[%0d]: got %h expected %h", k, bus.taps[W-1:0], r[W-1:0]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0]   maxp;
    logic [W-1:0]   minn;
    logic [SW-1:0]  exp_sum;
    maxp = {1'b0, {(W-1){1'b1}}};
    minn = {1'b1, {(W-1){1'b0}}};
    step(1'b0, 1'b1, 2, W'(0));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2, maxp);
`ifdef FK_DELAY_SUM_EN
    exp_sum = SW'(64'sd3 * ((64'sd1 <<< (W-1)) - 64'sd1));
`else
    exp_sum = '0;
`endif
    checks++; if (bus.taps !== {maxp, maxp, maxp}) begin errors++; $display("FAIL ext_pos_taps: got %h", bus.taps); end
    checks++; if (bus.tap_sum !== exp_sum) begin errors++; $display("FAIL ext_pos_sum: got %h expected %h", bus.tap_sum, exp_sum); end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2, minn);
`ifdef FK_DELAY_SUM_EN
    exp_sum = SW'(-64'sd3 * (64'sd1 <<< (W-1)));
`else
    exp_sum = '0;
`endif
    checks++; if (bus.taps !== {minn, minn, minn}) begin errors++; $display("FAIL ext_neg_taps: got %h", bus.taps); end
    checks++; if (bus.tap_sum !== exp_sum) begin errors++; $display("FAIL ext_neg_sum: got %h expected %h", bus.tap_sum, exp_sum); end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 1'b0, 0, W'(11));
    step(1'b1, 1'b0, 0, W'(12));
    bus.shift   = 1'b1;            // keep shifting across the next edge
    bus.ch_sel  = CW'(0);
    bus.in_data = W'(13);
    @(posedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    model_reset();
    #1;
    checks++; if (bus.taps !== '0 || bus.out_valid !== 1'b0 || bus.primed !== 1'b0) begin
      errors++; $display("FAIL midrst_out: got taps=%h v=%b p=%b expected all 0", bus.taps, bus.out_valid, bus.primed);
    end
    checks++; if (bus.out_ch !== '0 || bus.err !== 1'b0 || bus.tap_sum !== '0) begin
      errors++; $display("FAIL midrst_misc: got ch=%0d err=%b sum=%h expected all 0", bus.out_ch, bus.err, bus.tap_sum);
    end
    bus.shift = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 0, W'(1));
    checks++; if (bus.taps[W-1:0] !== W'(1) || bus.taps[2*W-1:W] !== W'(0) || bus.primed !== 1'b0) begin
      errors++; $display("FAIL postrst: got fk=%h fk1=%h p=%b expected fk=1 fk1=0 p=0", bus.taps[W-1:0], bus.taps[2*W-1:W], bus.primed);
    end
  endtask

  initial begin
    bus.shift   = 1'b0;
    bus.clr     = 1'b0;
    bus.ch_sel  = '0;
    bus.in_data = '0;
    model_reset();
    test_reset();
    test_fill();
    test_isolation();
    test_clr_shift();
    test_out_of_range();
    test_back_to_back();
    test_extremes();
    test_reset_midstream();
    step(1'b0, 1'b0, 0, W'(0));
    for (int k = 0; k < 4; k++) begin
      if (q.size() != 0) @(posedge clk);
    end
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
